codec_config_sequencer: RTL and testbench

Sequences the audio codec's register initialisation and later run-time volume writes over the shared I2C master. It replaces the free-running table-index counter with a handshaked state machine that has retry, timeout and error reporting. It sits between top-level control (`go`, volume request) and the I2C byte engine. It gates the audio streaming path (`stream_enable`) so flash/DAC playback starts only after the codec is fully configured.

---
 rtl/codec_config_sequencer.sv | 179 +++++++++++++++++
 tb/tb_codec_config_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_config_sequencer.sv
// Audio codec configuration sequencer: walks the 9-word init table over the I2C
// master with retry/timeout handling, then serves run-time headphone volume
// writes (left then right) and gates the audio streaming path.
module codec_config_sequencer #(
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned GAP_CYCLES     = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        go,
   output logic        i2c_start,
   output logic [15:0] i2c_word,
   input  logic        i2c_done,
   input  logic        i2c_nack,
   input  logic        vol_req,
   input  logic [6:0]  vol_data,
   output logic        vol_busy,
   output logic        cfg_done,
   output logic        cfg_error,
   output logic [3:0]  err_index,
   output logic        stream_enable
);

   localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned TmoW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   // Pointer values past the last word of each sequence
   localparam logic [3:0] InitEnd = 4'd9;
   localparam logic [3:0] VolEnd  = 4'd11;

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StGap, StRun, StError} state_e;

   state_e            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic [GapW-1:0]   gap_q, gap_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic [6:0]        vol_q, vol_d;
   logic [15:0]       word_q, word_d;
   logic              cfg_done_q, cfg_done_d;
   logic [3:0]        err_idx_q, err_idx_d;
   logic              busy_q, busy_d;
   logic              words_left;

   // Indices 0..8 are the init table, 9/10 the left/right volume registers
   function automatic logic [15:0] word_for(input logic [3:0] idx, input logic [6:0] vol);
      logic [15:0] w;
      case (idx)
         4'd0:    w = 16'h1E00;
         4'd1:    w = 16'h0C00;
         4'd2:    w = 16'h0812;
         4'd3:    w = 16'h0A00;
         4'd4:    w = 16'h0E23;
         4'd5:    w = 16'h102F;
         4'd6:    w = 16'h0460;
         4'd7:    w = 16'h0660;
         4'd8:    w = 16'h1201;
         4'd9:    w = {7'h02, 2'b00, vol};
         4'd10:   w = {7'h03, 2'b00, vol};
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

   // State register with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         retry_q    <= '0;
         gap_q      <= '0;
         tmo_q      <= '0;
         vol_q      <= '0;
         word_q     <= '0;
         cfg_done_q <= 1'b0;
         err_idx_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         retry_q    <= retry_d;
         gap_q      <= gap_d;
         tmo_q      <= tmo_d;
         vol_q      <= vol_d;
         word_q     <= word_d;
         cfg_done_q <= cfg_done_d;
         err_idx_q  <= err_idx_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state logic: handshake, retry, timeout and sequencing decisions
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      retry_d    = retry_q;
      gap_d      = gap_q;
      tmo_d      = tmo_q;
      vol_d      = vol_q;
      word_d     = word_q;
      cfg_done_d = cfg_done_q;
      err_idx_d  = err_idx_q;
      busy_d     = busy_q;
      // In GAP the pointer has already advanced past the word just acknowledged
      words_left = busy_q ? (idx_q != VolEnd) : (idx_q != InitEnd);

      unique case (state_q)
         StIdle: begin
            if (go) begin
               idx_d   = '0;
               retry_d = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            tmo_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            tmo_d = tmo_q + TmoW'(1);
            // done is checked first so it wins over a coincident timeout
            if (i2c_done && !i2c_nack) begin
               retry_d = '0;
               idx_d   = idx_q + 4'd1;
               gap_d   = '0;
               state_d = StGap;
            end else if ((i2c_done && i2c_nack) || (tmo_q == TmoW'(TIMEOUT_CYCLES - 1))) begin
               if (retry_q < RetryW'(MAX_RETRY)) begin
                  retry_d = retry_q + RetryW'(1);
                  gap_d   = '0;
                  state_d = StGap;
               end else begin
                  err_idx_d = idx_q;
                  state_d   = StError;
               end
            end
         end
         StGap: begin
            gap_d = gap_q + GapW'(1);
            if (gap_q == GapW'(GAP_CYCLES - 1)) begin
               if (words_left) begin
                  state_d = StIssue;
               end else begin
                  state_d = StRun;
                  if (busy_q) busy_d = 1'b0;
                  else        cfg_done_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (vol_req) begin
               busy_d  = 1'b1;
               vol_d   = vol_data;
               idx_d   = 4'd9;
               retry_d = '0;
               state_d = StIssue;
            end
         end
         StError: begin
            // Absorbing until Reset
         end
         default: state_d = StIdle;
      endcase

      // Word register is loaded on entry to ISSUE so it is valid with i2c_start
      if (state_d == StIssue) word_d = word_for(idx_d, vol_d);
   end

   assign i2c_start     = (state_q == StIssue);
   assign i2c_word      = word_q;
   assign vol_busy      = busy_q;
   assign cfg_done      = cfg_done_q;
   assign cfg_error     = (state_q == StError);
   assign err_index     = err_idx_q;
   assign stream_enable = cfg_done_q && (state_q != StError);

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Self-checking bench for codec_config_sequencer: reset/idle vectors, directed
// retry/timeout/volume/reset sequences and randomized sessions against a
// transaction-level model of the expected word stream.
module tb_codec_config_sequencer;

   localparam int MR  = 3;
   localparam int GAP = 4;
   localparam int TMO = 100;

   logic        CLK;
   logic        Reset;
   logic        go;
   logic        i2c_start;
   logic [15:0] i2c_word;
   logic        i2c_done;
   logic        i2c_nack;
   logic        vol_req;
   logic [6:0]  vol_data;
   logic        vol_busy;
   logic        cfg_done;
   logic        cfg_error;
   logic [3:0]  err_index;
   logic        stream_enable;

   codec_config_sequencer #(
      .MAX_RETRY      (MR),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CLK           (CLK),
      .Reset         (Reset),
      .go            (go),
      .i2c_start     (i2c_start),
      .i2c_word      (i2c_word),
      .i2c_done      (i2c_done),
      .i2c_nack      (i2c_nack),
      .vol_req       (vol_req),
      .vol_data      (vol_data),
      .vol_busy      (vol_busy),
      .cfg_done      (cfg_done),
      .cfg_error     (cfg_error),
      .err_index     (err_index),
      .stream_enable (stream_enable)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks;
   int n_errors;
   int n_starts;
   int nack_plan [11];
   bit poke_done;
   bit poke_vreq;
   logic [6:0]  vol_model;
   logic [15:0] init_tbl [9];

   typedef struct {
      logic        rst_n;
      logic        go;
      logic        done;
      logic        nack;
      logic        vreq;
      logic [6:0]  vdata;
      logic [24:0] exp;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [24:0] outs();
      return {i2c_start, i2c_word, cfg_done, cfg_error, stream_enable, vol_busy, err_index};
   endfunction

   function automatic logic [24:0] mk(input logic st, input logic [15:0] w, input logic cd,
                                      input logic ce, input logic se, input logic vb,
                                      input logic [3:0] ei);
      return {st, w, cd, ce, se, vb, ei};
   endfunction

   // Expected word for a sequence position, straight from the register map
   function automatic logic [15:0] exp_word(input int idx);
      if (idx < 9)  return init_tbl[idx];
      if (idx == 9) return {7'h02, 2'b00, vol_model};
      return {7'h03, 2'b00, vol_model};
   endfunction

   task automatic do_reset();
      Reset = 1'b0; go = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0; vol_req = 1'b0;
      tick();
      Reset = 1'b1;
      check("reset_state", outs(), 25'h0);
   endtask

   // Wait for an i2c_start pulse; optionally inject ignorable done/vol_req while waiting
   task automatic wait_start(input int budget, output logic [15:0] w, output bit seen,
                             output int waited);
      seen = 1'b0; waited = 0; w = '0;
      while (!seen && waited <= budget) begin
         if (i2c_start) begin
            seen = 1'b1;
            w    = i2c_word;
         end else begin
            i2c_done = poke_done ? 1'($urandom_range(0, 1)) : 1'b0;
            i2c_nack = 1'($urandom_range(0, 1));
            vol_req  = poke_vreq ? 1'($urandom_range(0, 1)) : 1'b0;
            vol_data = 7'($urandom);
            tick();
            waited++;
         end
      end
      i2c_done = 1'b0; i2c_nack = 1'b0; vol_req = 1'b0;
   endtask

   // Called in the ISSUE cycle: hold off lat cycles, then return done/nack
   task automatic do_txn(input int lat, input bit nack);
      logic [15:0] w0;
      w0 = i2c_word;
      for (int i = 0; i < lat; i++) begin
         if (i == 0 && poke_vreq) begin
            vol_req  = 1'b1;
            vol_data = 7'($urandom);
         end
         tick();
         vol_req = 1'b0;
         if (i == 0) check("start_pulse", i2c_start, 1'b0);
      end
      check("word_stable", i2c_word, w0);
      i2c_done = 1'b1; i2c_nack = nack;
      tick();
      i2c_done = 1'b0; i2c_nack = 1'b0;
   endtask

   // Play sequence positions first..last; err_at = failing index, -1 ok, -2 lost start
   task automatic play(input int first, input int last, input int lat_max, output int err_at);
      logic [15:0] w;
      bit seen, nack, acked, first_start;
      int waited, fails;
      err_at = -1;
      first_start = 1'b1;
      for (int idx = first; idx <= last && err_at == -1; idx++) begin
         fails = 0;
         acked = 1'b0;
         while (!acked && err_at == -1) begin
            wait_start(GAP + TMO + 10, w, seen, waited);
            check("start_seen", seen, 1'b1);
            if (!seen) begin
               err_at = -2;
            end else begin
               if (first_start) check("issue_latency", waited, 0);
               else check("gap_len", (waited >= GAP && waited <= GAP + 1), 1'b1);
               first_start = 1'b0;
               n_starts++;
               check("word", w, exp_word(idx));
               if (idx >= 9) check("vol_busy_stream", {vol_busy, stream_enable}, 2'b11);
               nack = (fails < nack_plan[idx]);
               do_txn($urandom_range(1, lat_max), nack);
               if (!nack) acked = 1'b1;
               else begin
                  fails++;
                  if (fails > MR) err_at = idx;
               end
            end
         end
      end
   endtask

   // Called in the cycle after the final done edge of a sequence
   task automatic finish_checks(input bit is_vol, input int err_at);
      logic [15:0] w;
      bit seen;
      int waited;
      if (err_at >= 0) begin
         check("err_state", {cfg_error, stream_enable, err_index}, {1'b1, 1'b0, 4'(err_at)});
         go = 1'b1; vol_req = 1'b1; vol_data = 7'h11;
         tick();
         go = 1'b0; vol_req = 1'b0;
         wait_start(40, w, seen, waited);
         check("error_lock", {seen, cfg_error}, 2'b01);
      end else if (err_at == -1) begin
         repeat (GAP - 1) tick();
         if (is_vol) check("vol_busy_gap", {vol_busy, stream_enable}, 2'b11);
         else check("cfg_early", {cfg_done, stream_enable}, 2'b00);
         tick();
         if (is_vol) check("vol_end", {cfg_done, cfg_error, stream_enable, vol_busy}, 4'b1010);
         else check("cfg_end", {cfg_done, cfg_error, stream_enable, vol_busy}, 4'b1010);
      end
   endtask

   task automatic start_cfg();
      go = 1'b1;
      tick();
      go = 1'b0;
      check("go_latency", {i2c_start, i2c_word}, {1'b1, 16'h1E00});
   endtask

   task automatic vol_cmd(input logic [6:0] d);
      vol_req = 1'b1; vol_data = d;
      tick();
      vol_req = 1'b0;
      check("vreq_latency", {i2c_start, vol_busy}, 2'b11);
      vol_model = d;
   endtask

   task automatic clear_plan();
      for (int k = 0; k < 11; k++) nack_plan[k] = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      bit seen;
      int waited, err_at, r;

      n_checks = 0; n_errors = 0; n_starts = 0;
      poke_done = 1'b0; poke_vreq = 1'b0; vol_model = '0;
      init_tbl = '{16'h1E00, 16'h0C00, 16'h0812, 16'h0A00, 16'h0E23,
                   16'h102F, 16'h0460, 16'h0660, 16'h1201};
      //          rst  go   done nack vreq vdata  expected outputs
      vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, mk(0, 16'h0000, 0, 0, 0, 0, 0)};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, mk(0, 16'h0000, 0, 0, 0, 0, 0)};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h33, mk(0, 16'h0000, 0, 0, 0, 0, 0)};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, mk(1, 16'h1E00, 0, 0, 0, 0, 0)};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, mk(0, 16'h1E00, 0, 0, 0, 0, 0)};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00, mk(0, 16'h1E00, 0, 0, 0, 0, 0)};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'h44, mk(0, 16'h1E00, 0, 0, 0, 0, 0)};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, mk(0, 16'h0000, 0, 0, 0, 0, 0)};

      Reset = 1'b0; go = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
      vol_req = 1'b0; vol_data = '0;
      repeat (2) tick();

      for (int i = 0; i < 8; i++) begin
         Reset = vecs[i].rst_n; go = vecs[i].go; i2c_done = vecs[i].done;
         i2c_nack = vecs[i].nack; vol_req = vecs[i].vreq; vol_data = vecs[i].vdata;
         tick();
         go = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0; vol_req = 1'b0;
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end
      Reset = 1'b1;

      // Happy path, then a volume update with dropped extra requests
      do_reset(); clear_plan(); n_starts = 0;
      start_cfg();
      play(0, 8, 3, err_at);
      finish_checks(1'b0, err_at);
      check("happy_starts", n_starts, 9);
      poke_vreq = 1'b1;
      vol_cmd(7'h79);
      check("vol_left_word", i2c_word, 16'h0479);
      play(9, 10, 3, err_at);
      poke_vreq = 1'b0;
      finish_checks(1'b1, err_at);
      wait_start(GAP + 20, w, seen, waited);
      check("vreq_dropped", {seen, stream_enable}, 2'b01);

      // NACK retry on index 3
      do_reset(); clear_plan(); n_starts = 0; nack_plan[3] = 2;
      start_cfg();
      play(0, 8, 3, err_at);
      finish_checks(1'b0, err_at);
      check("retry_starts", n_starts, 11);

      // Exhausted retries on index 5
      do_reset(); clear_plan(); n_starts = 0; nack_plan[5] = MR + 1;
      start_cfg();
      play(0, 8, 3, err_at);
      check("exhaust_at", err_at, 5);
      finish_checks(1'b0, err_at);
      check("exhaust_starts", n_starts, 9);

      // Timeout on index 0, every attempt
      do_reset(); clear_plan();
      go = 1'b1; tick(); go = 1'b0;
      for (int a = 0; a <= MR; a++) begin
         wait_start(GAP + TMO + 10, w, seen, waited);
         check("tmo_seen", seen, 1'b1);
         if (a > 0) check("tmo_regap", (waited >= GAP + 1 && waited <= GAP + 2), 1'b1);
         check("tmo_word", w, 16'h1E00);
         repeat (TMO) tick();
         if (a == MR) begin
            check("tmo_early", cfg_error, 1'b0);
            tick();
            check("tmo_error", {cfg_error, stream_enable, err_index}, 6'b100000);
         end
      end

      // done coincident with the timeout point wins
      do_reset(); clear_plan();
      go = 1'b1; tick(); go = 1'b0;
      repeat (TMO) tick();
      i2c_done = 1'b1; i2c_nack = 1'b0;
      tick();
      i2c_done = 1'b0;
      wait_start(GAP + TMO + 10, w, seen, waited);
      check("done_wins", {seen, w}, {1'b1, 16'h0C00});

      // Reset while waiting on index 4, stale done, restart
      do_reset(); clear_plan();
      start_cfg();
      play(0, 3, 3, err_at);
      wait_start(GAP + 10, w, seen, waited);
      check("mid_word", w, 16'h0E23);
      tick(); tick();
      Reset = 1'b0; tick(); Reset = 1'b1;
      check("reset_midwait", outs(), 25'h0);
      i2c_done = 1'b1; tick(); i2c_done = 1'b0;
      check("stale_done", outs(), 25'h0);
      start_cfg();

      // Randomized sessions
      for (int it = 0; it < 12; it++) begin
         do_reset();
         for (int k = 0; k < 11; k++) begin
            r = $urandom_range(0, 39);
            nack_plan[k] = (r == 39) ? MR + 1 : (r < 28) ? 0 : int'($urandom_range(1, MR));
         end
         poke_done = 1'($urandom_range(0, 1));
         poke_vreq = 1'($urandom_range(0, 1));
         start_cfg();
         play(0, 8, 6, err_at);
         finish_checks(1'b0, err_at);
         for (int v = 0; v < 3 && err_at == -1; v++) begin
            for (int k = 9; k < 11; k++) begin
               r = $urandom_range(0, 9);
               nack_plan[k] = (r == 9) ? MR + 1 : (r < 6) ? 0 : int'($urandom_range(1, MR));
            end
            vol_cmd(7'($urandom));
            play(9, 10, 6, err_at);
            finish_checks(1'b1, err_at);
         end
         poke_done = 1'b0;
         poke_vreq = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
